// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and decode helper.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The unused encoding 2'd3 is folded onto IDLE so a corrupted state recovers.
   function automatic logic [1:0] st_decode(input logic [1:0] st);
      return (st == 2'd3) ? ST_IDLE : st;
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell; the per-bit arithmetic element of serial_adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic p;

   assign p     = a ^ b;
   assign sum   = p ^ c_in;
   assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full_adder with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d, st;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             fa_sum, fa_cout;

   full_adder u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c_in  (carry_q),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   assign st        = st_decode(state_q);
   assign in_ready  = (st == ST_IDLE);
   assign out_valid = (st == ST_DONE);
   assign sum       = sum_sh_q;
   assign c_out     = carry_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      sum_sh_d = sum_sh_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      case (st)
         ST_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            // Counter is held at its last value so it never wraps.
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         sum_sh_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         sum_sh_q <= sum_sh_d;
      end
   end

   // Operand shifters carry no state visible at the outputs, so they need no reset.
   always_ff @(posedge clk) begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic c_msb_q, c_msb_d;

   // Carry into the MSB, captured on the edge that processes bit WIDTH-1.
   always_comb begin
      c_msb_d = c_msb_q;
      if (st == ST_RUN && cnt_q == CNT_LAST) begin
         c_msb_d = carry_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_msb_q <= 1'b0;
      end else begin
         c_msb_q <= c_msb_d;
      end
   end

   assign ovf = c_msb_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random and WIDTH=4 exhaustive.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   int         checks = 0;
   int         errors = 0;

   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
   logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8, ovf4;
`endif

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .c_in(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .c_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .c_in(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .c_out(cout4)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

   // Reference: unsigned sum of the operands, and two's-complement range check.
   function automatic int ref_add(input int a, input int b, input int cin);
      return a + b + cin;
   endfunction

   function automatic bit ref_ovf(input int w, input int a, input int b, input int cin);
      int half, sa, sb, s;
      half = 1 << (w - 1);
      sa = (a >= half) ? a - 2 * half : a;
      sb = (b >= half) ? b - 2 * half : b;
      s  = sa + sb + cin;
      return (s >= half) || (s < -half);
   endfunction

   // Presents operands, waits for acceptance, then counts edges until out_valid.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output bit to);
      int n;
      a8 = a; b8 = b; cin8 = cin; in_valid8 = 1'b1;
      to = 1'b0; lat = 0; n = 0;
      while (!in_ready8 && n < 30) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready8) to = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      while (!out_valid8 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid8) to = 1'b1;
   endtask

   task automatic pop8();
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid8, cout8, sum8} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: got out_valid=%b c_out=%b sum=%h, want 0/0/00", out_valid8, cout8, sum8);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b, want 0", ovf8);
      end
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready8 !== 1'b1 || in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got in_ready8=%b in_ready4=%b out_valid4=%b, want 1/1/0", in_ready8, in_ready4, out_valid4);
      end
   endtask

   task automatic test_directed();
      logic [7:0] ta [3];
      logic [7:0] tb [3];
      int lat, exp;
      bit to;
      ta[0] = 8'h00; tb[0] = 8'h00;
      ta[1] = 8'hFF; tb[1] = 8'h01;
      ta[2] = 8'h7F; tb[2] = 8'h01;
      for (int i = 0; i < 3; i++) begin
         send8(ta[i], tb[i], 1'b0, lat, to);
         exp = ref_add(int'(ta[i]), int'(tb[i]), 0);
         checks++;
         if (to || lat != 8) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d edges (timeout=%0b), want 8", i, lat, to);
         end
         checks++;
         if ({cout8, sum8} !== 9'(exp)) begin
            errors++;
            $display("FAIL directed_sum[%0d]: got c_out=%b sum=%h, want %h", i, cout8, sum8, 9'(exp));
         end
`ifdef SERIAL_ADDER_OVF_EN
         checks++;
         if (ovf8 !== ref_ovf(8, int'(ta[i]), int'(tb[i]), 0)) begin
            errors++;
            $display("FAIL directed_ovf[%0d]: got %b, want %b", i, ovf8, ref_ovf(8, int'(ta[i]), int'(tb[i]), 0));
         end
`endif
         pop8();
         checks++;
         if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL directed_release[%0d]: got in_ready=%b out_valid=%b, want 1/0", i, in_ready8, out_valid8);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat, n, bad_rdy, bad_hold;
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
      n = 0;
      while (!in_ready8 && n < 30) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      // New operands held with in_valid during RUN and DONE must be ignored.
      a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0;
      lat = 0; bad_rdy = 0;
      while (!out_valid8 && lat < 40) begin
         if (in_ready8 !== 1'b0) bad_rdy++;
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat != 8 || bad_rdy != 0) begin
         errors++;
         $display("FAIL bp_run: got latency=%0d in_ready_high_cycles=%0d, want 8/0", lat, bad_rdy);
      end
      bad_hold = 0;
      for (int k = 0; k < 5; k++) begin
         if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || {cout8, sum8} !== 9'h100) bad_hold++;
`ifdef SERIAL_ADDER_OVF_EN
         if (ovf8 !== 1'b0) bad_hold++;
`endif
         @(posedge clk); #1;
      end
      checks++;
      if (bad_hold != 0 || {cout8, sum8} !== 9'(ref_add(8'hAA, 8'h55, 1))) begin
         errors++;
         $display("FAIL bp_hold: got c_out=%b sum=%h unstable=%0d, want 1/00/0", cout8, sum8, bad_hold);
      end
      in_valid8 = 1'b0;
      pop8();
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1/0", in_ready8, out_valid8);
      end
   endtask

   task automatic test_reset_midrun();
      int n, seen, lat;
      bit to;
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 30) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (in_ready8 !== 1'b1 || sum8 !== 8'h00 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got in_ready=%b sum=%h out_valid=%b, want 1/00/0", in_ready8, sum8, out_valid8);
      end
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid8 === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midrun_no_valid: got %0d out_valid cycles, want 0", seen);
      end
      send8(8'h12, 8'h34, 1'b0, lat, to);
      checks++;
      if (to || {cout8, sum8} !== 9'h046) begin
         errors++;
         $display("FAIL midrun_fresh: got c_out=%b sum=%h (timeout=%0b), want 0/46", cout8, sum8, to);
      end
      pop8();
   endtask

   task automatic test_random8();
      logic [7:0] ra, rb;
      logic       rc;
      int         lat, hold, exp;
      bit         to;
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         hold = int'($urandom_range(0, 3));
         send8(ra, rb, rc, lat, to);
         repeat (hold) begin
            @(posedge clk); #1;
         end
         exp = ref_add(int'(ra), int'(rb), int'(rc));
         checks++;
         if (to || lat != 8 || {cout8, sum8} !== 9'(exp)) begin
            errors++;
            $display("FAIL random[%0d] %h+%h+%b: got c_out=%b sum=%h lat=%0d, want %h lat=8", i, ra, rb, rc, cout8, sum8, lat, 9'(exp));
         end
`ifdef SERIAL_ADDER_OVF_EN
         checks++;
         if (ovf8 !== ref_ovf(8, int'(ra), int'(rb), int'(rc))) begin
            errors++;
            $display("FAIL random_ovf[%0d] %h+%h+%b: got %b, want %b", i, ra, rb, rc, ovf8, ref_ovf(8, int'(ra), int'(rb), int'(rc)));
         end
`endif
         pop8();
      end
   endtask

   task automatic test_back_to_back();
      int n, lat, exp, av, bv, cv;
      in_valid4 = 1'b1; out_ready4 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         av = i & 15; bv = (i >> 4) & 15; cv = (i >> 8) & 1;
         a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv);
         n = 0;
         while (!in_ready4 && n < 20) begin
            @(posedge clk); #1; n++;
         end
         if (i > 0) begin
            checks++;
            if (n != 1) begin
               errors++;
               $display("FAIL b2b_ready[%0d]: got in_ready after %0d edges, want 1", i, n);
            end
         end
         @(posedge clk); #1;
         lat = 0;
         while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1; lat++;
         end
         exp = ref_add(av, bv, cv);
         checks++;
         if (lat != 4 || {cout4, sum4} !== 5'(exp)) begin
            errors++;
            $display("FAIL b2b[%0d] %0d+%0d+%0d: got c_out=%b sum=%h lat=%0d, want %h lat=4", i, av, bv, cv, cout4, sum4, lat, 5'(exp));
         end
`ifdef SERIAL_ADDER_OVF_EN
         checks++;
         if (ovf4 !== ref_ovf(4, av, bv, cv)) begin
            errors++;
            $display("FAIL b2b_ovf[%0d]: got %b, want %b", i, ovf4, ref_ovf(4, av, bv, cv));
         end
`endif
      end
      in_valid4 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midrun();
      test_random8();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
